// File: rtl/row_stream_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// row_stream_sequencer_pkg
// Shared types and default geometry for the input-side row sequencer that feeds
// the first CNN layer.
//   state_t : two-state sequencer FSM (filling a row / presenting a row)
//   row_t   : one image row at the default geometry, [pixel][channel][bits]
// -----------------------------------------------------------------------------
package row_stream_sequencer_pkg;

    localparam int DEFAULT_WIDTH       = 28;
    localparam int DEFAULT_HEIGHT      = 28;
    localparam int DEFAULT_VALUE_BITS  = 8;
    localparam int DEFAULT_IN_CHANNELS = 1;

    typedef enum logic [0:0] {
        ST_FILL    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    typedef logic [DEFAULT_WIDTH-1:0][DEFAULT_IN_CHANNELS-1:0][DEFAULT_VALUE_BITS-1:0] row_t;

endpackage

// File: rtl/row_stream_sequencer.sv
// -----------------------------------------------------------------------------
// row_stream_sequencer
// Unpacks a 32-bit word stream into complete image rows and hands each row to
// the first CNN layer with a valid/accept handshake. Counts rows and frames and
// stalls the word source while a finished row has not yet been taken.
//
// Ports
//   clock_i          : clock, rising edge
//   reset_n_i        : asynchronous active-low reset
//   in_data_i        : packed values, value k at [VALUE_BITS*k +: VALUE_BITS]
//   in_valid_i       : in_data_i valid
//   upstream_stall_o : 1 = word not accepted this cycle
//   flush_i          : synchronous drop of partial row, restart at row 0
//   row_o            : assembled row [pixel][channel][bits]
//   row_valid_o      : row_o holds a complete row
//   row_accept_i     : layer takes the row
//   row_last_o       : row_o is the last row of the image
//   frame_count_o    : images completed, wraps at 2^16
// -----------------------------------------------------------------------------
module row_stream_sequencer
    import row_stream_sequencer_pkg::*;
#(
    parameter int VALUES_PER_WORD = 1,
    parameter int VALUE_BITS      = DEFAULT_VALUE_BITS,
    parameter int WORD_BITS       = 32,
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int HEIGHT          = DEFAULT_HEIGHT,
    parameter int IN_CHANNELS     = DEFAULT_IN_CHANNELS
) (
    input  logic                                                clock_i,
    input  logic                                                reset_n_i,
    input  logic [WORD_BITS-1:0]                                in_data_i,
    input  logic                                                in_valid_i,
    output logic                                                upstream_stall_o,
    input  logic                                                flush_i,
    output logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0]   row_o,
    output logic                                                row_valid_o,
    input  logic                                                row_accept_i,
    output logic                                                row_last_o,
    output logic [15:0]                                         frame_count_o
);

    localparam int WORDS_PER_ROW = (WIDTH * IN_CHANNELS) / VALUES_PER_WORD;
    localparam int ROW_BITS      = WIDTH * IN_CHANNELS * VALUE_BITS;
    localparam int WIDX_W        = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int RIDX_W        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    // Geometry must split into whole words and fit the input word.
    if (((WIDTH * IN_CHANNELS) % VALUES_PER_WORD) != 0) begin : g_chk_div
        $error("WIDTH*IN_CHANNELS must be a multiple of VALUES_PER_WORD");
    end
    if (VALUES_PER_WORD * VALUE_BITS > WORD_BITS) begin : g_chk_word
        $error("VALUES_PER_WORD*VALUE_BITS exceeds WORD_BITS");
    end

    state_t              state_q, state_d;
    logic [WIDX_W-1:0]   word_q,  word_d;
    logic [RIDX_W-1:0]   ridx_q,  ridx_d;
    logic [15:0]         frame_q, frame_d;
    // Flat row storage: value with flat index f (pixel*IN_CHANNELS+channel)
    // lives at bits [f*VALUE_BITS +: VALUE_BITS], matching row_o's packing.
    logic [ROW_BITS-1:0] row_q,   row_d;
    logic                word_take_s;

    // Upper input bits are unused when fewer values than the word holds are packed.
    logic unused_in_s;
    assign unused_in_s = ^in_data_i;

    // A word is taken only while filling; in PRESENT the source holds it.
    assign word_take_s = in_valid_i && (state_q == ST_FILL);

    // Sequencer registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_FILL;
            word_q  <= {WIDX_W{1'b0}};
            ridx_q  <= {RIDX_W{1'b0}};
            frame_q <= 16'd0;
            row_q   <= {ROW_BITS{1'b0}};
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            ridx_q  <= ridx_d;
            frame_q <= frame_d;
            row_q   <= row_d;
        end
    end

    // Next-state logic: flush overrides both the word and the row handshake.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ridx_d  = ridx_q;
        frame_d = frame_q;
        row_d   = row_q;
        if (flush_i) begin
            state_d = ST_FILL;
            word_d  = {WIDX_W{1'b0}};
            ridx_d  = {RIDX_W{1'b0}};
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (word_take_s) begin
                        for (int v = 0; v < VALUES_PER_WORD; v++) begin
                            row_d[(int'(word_q) * VALUES_PER_WORD + v) * VALUE_BITS +: VALUE_BITS] =
                                in_data_i[v * VALUE_BITS +: VALUE_BITS];
                        end
                        if (word_q == WIDX_W'(WORDS_PER_ROW - 1)) begin
                            state_d = ST_PRESENT;
                            word_d  = {WIDX_W{1'b0}};
                        end else begin
                            word_d  = word_q + WIDX_W'(1);
                        end
                    end else begin
                        word_d = word_q;
                    end
                end
                ST_PRESENT: begin
                    if (row_accept_i) begin
                        state_d = ST_FILL;
                        if (ridx_q == RIDX_W'(HEIGHT - 1)) begin
                            ridx_d  = {RIDX_W{1'b0}};
                            frame_d = frame_q + 16'd1;
                        end else begin
                            ridx_d  = ridx_q + RIDX_W'(1);
                        end
                    end else begin
                        state_d = ST_PRESENT;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    word_d  = {WIDX_W{1'b0}};
                end
            endcase
        end
    end

    // Handshake outputs decode directly from the state register, so the stall
    // is already registered and drops only after the row transfer edge.
    assign row_valid_o      = (state_q == ST_PRESENT);
    assign upstream_stall_o = (state_q == ST_PRESENT);
    assign row_last_o       = (state_q == ST_PRESENT) && (ridx_q == RIDX_W'(HEIGHT - 1));
    assign frame_count_o    = frame_q;
    assign row_o            = row_q;

endmodule

// File: tb/tb_row_stream_sequencer.sv
module tb_row_stream_sequencer;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int IC = 1;
    localparam int VB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance with one value per word (main model-checked instance).
    logic [31:0]                    d1;
    logic                           v1, acc1, fl1;
    logic                           stall1, rv1, last1;
    logic [15:0]                    fc1;
    logic [W-1:0][IC-1:0][VB-1:0]   row1;

    // Instance with four values per word (table-checked).
    logic [31:0]                    d4;
    logic                           v4, acc4, fl4;
    logic                           stall4, rv4, last4;
    logic [15:0]                    fc4;
    logic [W-1:0][IC-1:0][VB-1:0]   row4;

    row_stream_sequencer #(.VALUES_PER_WORD(1)) dut1 (
        .clock_i(clk), .reset_n_i(rst_n), .in_data_i(d1), .in_valid_i(v1),
        .upstream_stall_o(stall1), .flush_i(fl1), .row_o(row1),
        .row_valid_o(rv1), .row_accept_i(acc1), .row_last_o(last1),
        .frame_count_o(fc1)
    );

    row_stream_sequencer #(.VALUES_PER_WORD(4)) dut4 (
        .clock_i(clk), .reset_n_i(rst_n), .in_data_i(d4), .in_valid_i(v4),
        .upstream_stall_o(stall4), .flush_i(fl4), .row_o(row4),
        .row_valid_o(rv4), .row_accept_i(acc4), .row_last_o(last4),
        .frame_count_o(fc4)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural reference: values collected so far, a ready flag for a
    // finished row, the row number within the image and the frame count.
    logic [7:0] m_fill[$];
    logic [7:0] m_row[W];
    bit         m_ready;
    int         m_rowidx;
    int         m_frames;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fill.delete();
        for (int i = 0; i < W; i++) m_row[i] = 8'd0;
        m_ready  = 1'b0;
        m_rowidx = 0;
        m_frames = 0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] d, input logic a, input logic f);
        if (f) begin
            m_fill.delete();
            m_ready  = 1'b0;
            m_rowidx = 0;
        end else if (m_ready) begin
            if (a) begin
                m_ready = 1'b0;
                if (m_rowidx == H - 1) begin
                    m_rowidx = 0;
                    m_frames = (m_frames + 1) % 65536;
                end else begin
                    m_rowidx++;
                end
            end
        end else if (v) begin
            m_fill.push_back(d[7:0]);
            if (m_fill.size() == W * IC) begin
                for (int i = 0; i < W; i++) m_row[i] = m_fill[i];
                m_fill.delete();
                m_ready = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        logic [W*VB-1:0] exp_row;
        check("stall", {255'd0, stall1}, {255'd0, m_ready});
        check("valid", {255'd0, rv1}, {255'd0, m_ready});
        check("last", {255'd0, last1}, {255'd0, (m_ready && m_rowidx == H - 1)});
        check("frame", {240'd0, fc1}, {240'd0, 16'(m_frames)});
        if (m_ready) begin
            for (int i = 0; i < W; i++) exp_row[i*VB +: VB] = m_row[i];
            check("row", {32'd0, row1}, {32'd0, exp_row});
        end
    endtask

    // One clock on dut1: drive, clock, advance the model, compare after the edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic a, input logic f);
        v1 = v; d1 = d; acc1 = a; fl1 = f;
        @(posedge clk);
        model_step(v, d, a, f);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        a;
        logic        f;
        logic        ev;
        logic        es;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [31:0] packed_word(input int w);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4 * w);
        b1 = 8'(4 * w + 1);
        b2 = 8'(4 * w + 2);
        b3 = 8'(4 * w + 3);
        return {b3, b2, b1, b0};
    endfunction

    initial begin
        logic [W*VB-1:0] held;
        logic [W*VB-1:0] exp4;
        logic [7:0]      first_byte;
        int              guard;

        // Table for the 4-values-per-word instance: 7 words, hold, accept, refill.
        for (int i = 0; i < 7; i++)
            tbl[i] = '{v: 1'b1, d: packed_word(i), a: 1'b0, f: 1'b0, ev: (i == 6), es: (i == 6)};
        tbl[7]  = '{v: 1'b1, d: 32'hDEADBEEF, a: 1'b0, f: 1'b0, ev: 1'b1, es: 1'b1};
        tbl[8]  = '{v: 1'b1, d: 32'hDEADBEEF, a: 1'b1, f: 1'b0, ev: 1'b0, es: 1'b0};
        tbl[9]  = '{v: 1'b1, d: packed_word(0), a: 1'b0, f: 1'b0, ev: 1'b0, es: 1'b0};
        tbl[10] = '{v: 1'b0, d: 32'd0, a: 1'b0, f: 1'b1, ev: 1'b0, es: 1'b0};
        tbl[11] = '{v: 1'b0, d: 32'd0, a: 1'b0, f: 1'b0, ev: 1'b0, es: 1'b0};

        rst_n = 1'b0;
        v1 = 1'b0; d1 = 32'd0; acc1 = 1'b0; fl1 = 1'b0;
        v4 = 1'b0; d4 = 32'd0; acc4 = 1'b0; fl4 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {255'd0, rv1}, 256'd0);
        check("rst_stall", {255'd0, stall1}, 256'd0);
        check("rst_last", {255'd0, last1}, 256'd0);
        check("rst_frame", {240'd0, fc1}, 256'd0);
        check("rst_row", {32'd0, row1}, 256'd0);
        rst_n = 1'b1;

        // Row of words 0..27 with accept held high.
        for (int i = 0; i < W; i++) cyc(1'b1, 32'(i), 1'b1, 1'b0);
        check("r0_valid", {255'd0, rv1}, 256'd1);
        check("r0_pix5", {248'd0, row1[5][0]}, 256'd5);
        check("r0_pix27", {248'd0, row1[27][0]}, 256'd27);
        check("r0_last", {255'd0, last1}, 256'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Completed row held for 10 cycles with the source still offering a word.
        for (int i = 0; i < W; i++) cyc(1'b1, 32'(100 + i), 1'b0, 1'b0);
        held = row1;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 32'hAA, 1'b0, 1'b0);
            check("hold_stall", {255'd0, stall1}, 256'd1);
            check("hold_row", {32'd0, row1}, {32'd0, held});
        end
        cyc(1'b1, 32'hAA, 1'b1, 1'b0);
        check("xfer_stall", {255'd0, stall1}, 256'd0);

        // Stream until the last row of the image is presented.
        guard = 0;
        while (!(m_ready && m_rowidx == H - 1) && guard < 2000) begin
            cyc(1'b1, $urandom, 1'b1, 1'b0);
            guard++;
        end
        check("lastrow_reached", {255'd0, (guard < 2000)}, 256'd1);
        check("lastrow_flag", {255'd0, last1}, 256'd1);
        check("lastrow_frame", {240'd0, fc1}, 256'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        check("frame_inc", {240'd0, fc1}, 256'd1);
        for (int i = 0; i < W; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        check("next_row_last", {255'd0, last1}, 256'd0);
        check("next_row_valid", {255'd0, rv1}, 256'd1);

        // Flush together with accept while presenting.
        cyc(1'b1, 32'h55, 1'b1, 1'b1);
        check("flush_valid", {255'd0, rv1}, 256'd0);
        check("flush_frame", {240'd0, fc1}, 256'd1);
        for (int i = 0; i < W; i++) cyc(1'b1, $urandom, 1'b1, 1'b0);
        check("flush_row0_last", {255'd0, last1}, 256'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset after 10 words of a row.
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'(i + 7), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_row", {32'd0, row1}, 256'd0);
        check("arst_frame", {240'd0, fc1}, 256'd0);
        check("arst_valid", {255'd0, rv1}, 256'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        first_byte = 8'($urandom_range(1, 255));
        cyc(1'b1, {24'd0, first_byte}, 1'b0, 1'b0);
        for (int i = 1; i < W; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        check("arst_first_pix", {248'd0, row1[0][0]}, {248'd0, first_byte});
        check("arst_valid_after", {255'd0, rv1}, 256'd1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 5),
                ($urandom_range(0, 99) == 0));
        end
        v1 = 1'b0; acc1 = 1'b0; fl1 = 1'b0;

        // Table-driven run on the 4-values-per-word instance.
        for (int i = 0; i < W; i++) exp4[i*VB +: VB] = 8'(i);
        for (int i = 0; i < 12; i++) begin
            v4 = tbl[i].v; d4 = tbl[i].d; acc4 = tbl[i].a; fl4 = tbl[i].f;
            @(posedge clk);
            #1;
            check("vpw4_valid", {255'd0, rv4}, {255'd0, tbl[i].ev});
            check("vpw4_stall", {255'd0, stall4}, {255'd0, tbl[i].es});
            check("vpw4_last", {255'd0, last4}, 256'd0);
            if (i == 6) begin
                check("vpw4_row", {32'd0, row4}, {32'd0, exp4});
                check("vpw4_pix3", {248'd0, row4[3][0]}, 256'd3);
            end
        end
        check("vpw4_frame", {240'd0, fc4}, 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
